// File: rtl/dmem_access_ctrl_if.sv
// Data-memory req/ack bus between the MEM-stage access controller and dmem.
// The master side issues requests; the slave side returns data and ack.
interface dmem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: one req/ack transaction per load/store,
// lane steering, load extension, misalign and timeout faults.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead_M,
  input  logic                  memWrite_M,
  input  logic [31:0]           alu_rsl_M,
  input  logic [31:0]           write_Data_M,
  input  logic [2:0]            mode_M,
  dmem_access_ctrl_if.master    bus,
  output logic                  stall_M,
  output logic [31:0]           load_data_M,
  output logic                  load_valid,
  output logic                  misalign_fault,
  output logic                  access_fault
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t      state, state_nx;
  logic        acc, bad, issue, tmo;
  logic [1:0]  off;
  logic [3:0]  be_nx;
  logic [31:0] wd_nx;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, ld_q, ld_ext, sh;
  logic [3:0]  be_q;
  logic [2:0]  mode_q;
  logic [1:0]  off_q;
  logic [15:0] half;
  logic [7:0]  byt;
  logic [CNT_W-1:0] cnt;

  assign acc = memRead_M | memWrite_M;
  assign off = alu_rsl_M[1:0];
  assign tmo = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    bad   = 1'b0;
    be_nx = 4'b0000;
    wd_nx = write_Data_M;
    unique case (mode_M)
      3'b000, 3'b100: begin
        be_nx = 4'b0001 << off;
        wd_nx = {4{write_Data_M[7:0]}};
      end
      3'b001, 3'b101: begin
        bad   = off[0];
        be_nx = off[1] ? 4'b1100 : 4'b0011;
        wd_nx = {2{write_Data_M[15:0]}};
      end
      3'b010: begin
        bad   = |off;
        be_nx = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    sh   = bus.bus_rdata >> {off_q, 3'b000};
    byt  = sh[7:0];
    half = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    unique case (mode_q)
      3'b000:  ld_ext = {{24{byt[7]}}, byt};
      3'b100:  ld_ext = {24'd0, byt};
      3'b001:  ld_ext = {{16{half[15]}}, half};
      3'b101:  ld_ext = {16'd0, half};
      default: ld_ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    stall_M        = 1'b0;
    load_valid     = 1'b0;
    misalign_fault = 1'b0;
    access_fault   = 1'b0;
    issue          = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc && bad) begin
          misalign_fault = 1'b1;
        end else if (acc) begin
          stall_M  = 1'b1;
          issue    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        stall_M = 1'b1;
        if (bus.bus_ack) state_nx = DONE;
        else if (tmo)    state_nx = ERR;
      end
      DONE: begin
        load_valid = ~we_q;
        state_nx   = IDLE;
      end
      ERR: begin
        access_fault = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // held-in-reset pipeline must not see a stall or fault from live inputs
    if (rst) begin
      stall_M        = 1'b0;
      misalign_fault = 1'b0;
      issue          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      mode_q  <= '0;
      off_q   <= '0;
      cnt     <= '0;
      ld_q    <= '0;
    end else if (issue) begin
      req_q   <= 1'b1;
      we_q    <= memWrite_M;
      addr_q  <= {alu_rsl_M[31:2], 2'b00};
      be_q    <= be_nx;
      wdata_q <= wd_nx;
      mode_q  <= mode_M;
      off_q   <= off;
      cnt     <= '0;
    end else if (state == WAIT) begin
      if (bus.bus_ack) begin
        req_q <= 1'b0;
        if (!we_q) ld_q <= ld_ext;
      end else if (tmo) begin
        req_q <= 1'b0;
        ld_q  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign load_data_M   = ld_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: loads, stores, lane steering,
// faults, timeout boundary, async reset and back-to-back accesses.
module tb_dmem_access_ctrl;
  logic        clk;
  logic        rst;
  logic        memRead_M, memWrite_M;
  logic [31:0] alu_rsl_M, write_Data_M;
  logic [2:0]  mode_M;
  logic        stall_M, load_valid, misalign_fault, access_fault;
  logic [31:0] load_data_M;
  int          total = 0;
  int          bad_n = 0;
  int          txn = 0;
  int          hi;
  int          t0;

  dmem_access_ctrl_if bus();

  dmem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .memRead_M      (memRead_M),
    .memWrite_M     (memWrite_M),
    .alu_rsl_M      (alu_rsl_M),
    .write_Data_M   (write_Data_M),
    .mode_M         (mode_M),
    .bus            (bus),
    .stall_M        (stall_M),
    .load_data_M    (load_data_M),
    .load_valid     (load_valid),
    .misalign_fault (misalign_fault),
    .access_fault   (access_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.bus_req && bus.bus_ack) txn <= txn + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] m);
    @(negedge clk);
    memRead_M = rd; memWrite_M = wr; alu_rsl_M = a;
    write_Data_M = d; mode_M = m; bus.bus_ack = 1'b0;
    #1;
  endtask

  task automatic ack_step(input logic [31:0] rd);
    @(negedge clk);
    bus.bus_ack = 1'b1; bus.bus_rdata = rd;
    #1;
  endtask

  task automatic wait_step();
    @(negedge clk);
    bus.bus_ack = 1'b0;
    #1;
  endtask

  task automatic idle_step();
    @(negedge clk);
    bus.bus_ack = 1'b0; memRead_M = 1'b0; memWrite_M = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    memRead_M = 0; memWrite_M = 0; alu_rsl_M = 0;
    write_Data_M = 0; mode_M = 0;
    bus.bus_ack = 0; bus.bus_rdata = 0;
    @(negedge clk); #1;
    chk("rst_req", bus.bus_req, 0);
    chk("rst_stall", stall_M, 0);
    chk("rst_ld", load_data_M, 0);
    chk("rst_be", bus.bus_be, 0);
    @(negedge clk); rst = 1'b0;

    // LW 0x100, ack in first WAIT cycle
    drive(1, 0, 32'h100, 0, 3'b010);
    chk("lw_stall0", stall_M, 1);
    chk("lw_req0", bus.bus_req, 0);
    ack_step(32'hDEADBEEF);
    chk("lw_req1", bus.bus_req, 1);
    chk("lw_stall1", stall_M, 1);
    chk("lw_be", bus.bus_be, 4'b1111);
    chk("lw_addr", bus.bus_addr, 32'h100);
    chk("lw_we", bus.bus_we, 0);
    idle_step();
    chk("lw_stall2", stall_M, 0);
    chk("lw_valid", load_valid, 1);
    chk("lw_data", load_data_M, 32'hDEADBEEF);
    chk("lw_req2", bus.bus_req, 0);
    idle_step();
    chk("lw_valid_pulse", load_valid, 0);
    chk("lw_data_hold", load_data_M, 32'hDEADBEEF);

    // SB 0x103
    drive(0, 1, 32'h103, 32'h000000A5, 3'b000);
    ack_step(0);
    chk("sb_we", bus.bus_we, 1);
    chk("sb_be", bus.bus_be, 4'b1000);
    chk("sb_wdata", bus.bus_wdata, 32'hA5A5A5A5);
    chk("sb_addr", bus.bus_addr, 32'h100);
    idle_step();
    chk("sb_novalid", load_valid, 0);

    // LH / LHU 0x102, LB 0x101
    drive(1, 0, 32'h102, 0, 3'b001);
    ack_step(32'h80010000);
    chk("lh_be", bus.bus_be, 4'b1100);
    idle_step();
    chk("lh_data", load_data_M, 32'hFFFF8001);
    drive(1, 0, 32'h102, 0, 3'b101);
    ack_step(32'h80010000);
    idle_step();
    chk("lhu_data", load_data_M, 32'h00008001);
    drive(1, 0, 32'h101, 0, 3'b000);
    ack_step(32'h0000FF00);
    chk("lb_be", bus.bus_be, 4'b0010);
    idle_step();
    chk("lb_data", load_data_M, 32'hFFFFFFFF);
    drive(1, 0, 32'h101, 0, 3'b100);
    ack_step(32'h0000FF00);
    idle_step();
    chk("lbu_data", load_data_M, 32'h000000FF);

    // misaligned word and illegal mode
    drive(1, 0, 32'h102, 0, 3'b010);
    chk("mis_flag", misalign_fault, 1);
    chk("mis_stall", stall_M, 0);
    idle_step();
    chk("mis_noreq", bus.bus_req, 0);
    chk("mis_pulse", misalign_fault, 0);
    drive(1, 0, 32'h100, 0, 3'b011);
    chk("ill_flag", misalign_fault, 1);
    chk("ill_stall", stall_M, 0);
    idle_step();
    chk("ill_noreq", bus.bus_req, 0);

    // timeout: 16 WAIT cycles with no ack
    drive(1, 0, 32'h200, 0, 3'b010);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      wait_step();
      if (stall_M && bus.bus_req && !access_fault) hi++;
    end
    chk("tmo_wait_cycles", hi, 16);
    idle_step();
    chk("tmo_fault", access_fault, 1);
    chk("tmo_req", bus.bus_req, 0);
    chk("tmo_stall", stall_M, 0);
    chk("tmo_ld0", load_data_M, 0);
    chk("tmo_novalid", load_valid, 0);
    idle_step();
    chk("tmo_pulse", access_fault, 0);
    drive(0, 1, 32'h204, 32'h11223344, 3'b010);
    ack_step(0);
    chk("tmo_next_req", bus.bus_req, 1);
    chk("tmo_next_wdata", bus.bus_wdata, 32'h11223344);
    idle_step();

    // ack on the last allowed WAIT cycle
    drive(1, 0, 32'h300, 0, 3'b010);
    repeat (15) wait_step();
    ack_step(32'h0BADF00D);
    chk("late_req", bus.bus_req, 1);
    chk("late_nofault_w", access_fault, 0);
    idle_step();
    chk("late_valid", load_valid, 1);
    chk("late_nofault", access_fault, 0);
    chk("late_data", load_data_M, 32'h0BADF00D);
    idle_step();
    chk("late_nofault2", access_fault, 0);

    // async reset in WAIT
    drive(0, 1, 32'h400, 32'h5, 3'b010);
    wait_step();
    chk("arst_pre_req", bus.bus_req, 1);
    rst = 1'b1;
    #1;
    chk("arst_req", bus.bus_req, 0);
    chk("arst_stall", stall_M, 0);
    idle_step();
    rst = 1'b0;
    idle_step();
    chk("arst_idle_req", bus.bus_req, 0);

    // back-to-back SW then LW
    t0 = txn;
    drive(0, 1, 32'h500, 32'h12345678, 3'b010);
    ack_step(0);
    chk("b2b_sw_we", bus.bus_we, 1);
    chk("b2b_sw_wdata", bus.bus_wdata, 32'h12345678);
    drive(1, 0, 32'h504, 0, 3'b010);
    chk("b2b_done_stall", stall_M, 0);
    drive(1, 0, 32'h504, 0, 3'b010);
    chk("b2b_lw_stall", stall_M, 1);
    chk("b2b_lw_req0", bus.bus_req, 0);
    ack_step(32'hCAFEF00D);
    chk("b2b_lw_addr", bus.bus_addr, 32'h504);
    chk("b2b_lw_we", bus.bus_we, 0);
    idle_step();
    chk("b2b_lw_valid", load_valid, 1);
    chk("b2b_lw_data", load_data_M, 32'hCAFEF00D);
    idle_step();
    chk("b2b_txn", txn - t0, 2);

    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end
endmodule
